// File: rtl/ysyx_23060077_isram_rsp.sv
// Instruction SRAM read responder for the IFU fetch port: latches a burst request,
// waits a fixed latency, then streams one word per cycle. It can be preloaded while idle.
module ysyx_23060077_isram_rsp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE = 'h2000_0000,
  parameter int LATENCY = 2,
  localparam int IDX_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r_valid_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic [LEN_WIDTH-1:0]  r_len_i,
  output logic                  r_ready_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  r_last_o,
  output logic                  err_o,
  input  logic                  load_we_i,
  input  logic [IDX_WIDTH-1:0]  load_idx_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  load_ready_o
);

  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * DEPTH);
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [3:0]            lat_cnt;
  logic [IDX_WIDTH-1:0]  word_idx;
  logic                  in_range;
  logic                  is_last;
  logic                  accept;
  logic                  beat;

  // Subtracting BASE first makes wrapped addresses below BASE land far outside SPAN.
  assign offset   = addr - BASE;
  assign in_range = offset < SPAN;
  assign word_idx = offset[IDX_WIDTH+1:2];
  assign is_last  = beat_cnt == len;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (r_valid_i) next_state = (LATENCY == 0) ? S_BEAT : S_WAIT;
      S_WAIT: if (lat_cnt <= 4'd1) next_state = S_BEAT;
      S_BEAT: if (is_last) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    accept       = 1'b0;
    beat         = 1'b0;
    load_ready_o = 1'b0;
    case (state)
      S_IDLE: begin
        load_ready_o = 1'b1;
        accept       = r_valid_i;
      end
      S_BEAT: beat = 1'b1;
      default: ;
    endcase
  end

  // Preload is not reset so boot images survive a core reset.
  always_ff @(posedge clk) begin
    if (load_we_i && load_ready_o) mem[load_idx_i] <= load_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready_o <= 1'b0;
      r_last_o  <= 1'b0;
      r_data_o  <= '0;
      err_o     <= 1'b0;
      addr      <= '0;
      len       <= '0;
      beat_cnt  <= '0;
      lat_cnt   <= '0;
    end else begin
      r_ready_o <= beat;
      r_last_o  <= beat && is_last;
      r_data_o  <= (beat && in_range) ? mem[word_idx] : '0;
      if (beat && !in_range) err_o <= 1'b1;
      if (accept) begin
        addr     <= r_addr_i & ~ADDR_WIDTH'(3);
        len      <= r_len_i;
        beat_cnt <= '0;
        lat_cnt  <= LAT_INIT;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end else if (beat) begin
        addr     <= addr + ADDR_WIDTH'(4);
        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_isram_rsp.sv
// Directed bench for the fetch SRAM responder: a scoreboard of expected beats (data,
// last, cycle, sticky error) is filled at each accept and drained as beats appear.
module tb_ysyx_23060077_isram_rsp;

  localparam int LAT = 2;
  localparam int DEPTH = 4096;
  localparam logic [31:0] BASE = 32'h2000_0000;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
    logic        err;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        r_valid_i;
  logic [31:0] r_addr_i;
  logic [7:0]  r_len_i;
  logic        r_ready_o;
  logic [31:0] r_data_o;
  logic        r_last_o;
  logic        err_o;
  logic        load_we_i;
  logic [11:0] load_idx_i;
  logic [31:0] load_data_i;
  logic        load_ready_o;

  beat_t       sb[$];
  logic [31:0] model [DEPTH];
  logic        err_model;
  logic        mon_on;
  int          cyc;
  int          checks;
  int          failures;

  ysyx_23060077_isram_rsp #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8), .DEPTH(DEPTH),
    .BASE(BASE), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_len_i(r_len_i),
    .r_ready_o(r_ready_o), .r_data_o(r_data_o), .r_last_o(r_last_o), .err_o(err_o),
    .load_we_i(load_we_i), .load_idx_i(load_idx_i), .load_data_i(load_data_i),
    .load_ready_o(load_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_output();
    beat_t e;
    if (r_ready_o === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("beat_data", r_data_o, e.data);
      check_eq("beat_last", 32'(r_last_o), 32'(e.last));
      check_eq("beat_cycle", cyc, e.cyc);
      check_eq("beat_err", 32'(err_o), 32'(e.err));
      if (e.last) r_valid_i = 1'b0;
    end else begin
      check_eq("ready_idle", 32'(r_ready_o), 32'd0);
      check_eq("data_idle", r_data_o, 32'd0);
      check_eq("last_idle", 32'(r_last_o), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_on) check_output();
  endtask

  task automatic load_word(input logic [11:0] idx, input logic [31:0] data);
    check_eq("load_ready_idle", 32'(load_ready_o), 32'd1);
    load_we_i   = 1'b1;
    load_idx_i  = idx;
    load_data_i = data;
    model[idx]  = data;
    tick();
    load_we_i = 1'b0;
  endtask

  task automatic push_burst(input logic [31:0] start, input int len, input int t_acc);
    beat_t       e;
    logic [31:0] a;
    logic [31:0] off;
    for (int k = 0; k <= len; k++) begin
      a   = (start & ~32'd3) + 32'(4 * k);
      off = a - BASE;
      if (off < 32'(4 * DEPTH)) begin
        e.data = model[off[13:2]];
      end else begin
        e.data    = 32'd0;
        err_model = 1'b1;
      end
      e.last = (k == len);
      e.cyc  = t_acc + 1 + LAT + k;
      e.err  = err_model;
      sb.push_back(e);
    end
  endtask

  // Request is accepted at the next edge; addr/len are then scrambled to prove they are latched.
  task automatic issue(input logic [31:0] addr, input logic [7:0] len);
    r_valid_i = 1'b1;
    r_addr_i  = addr;
    r_len_i   = len;
    tick();
    push_burst(addr, int'(len), cyc);
    r_addr_i = 32'hDEAD_BEE0;
    r_len_i  = 8'd0;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) tick();
    check_eq("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; mon_on = 1'b0; err_model = 1'b0;
    reset = 1'b1; r_valid_i = 1'b0; r_addr_i = '0; r_len_i = '0;
    load_we_i = 1'b0; load_idx_i = '0; load_data_i = '0;
    repeat (3) tick();
    reset  = 1'b0;
    mon_on = 1'b1;
    tick();
    check_eq("reset_err", 32'(err_o), 32'd0);
    check_eq("reset_load_ready", 32'(load_ready_o), 32'd1);

    load_word(12'd0, 32'h0000_0413);
    for (int i = 1; i < 16; i++) load_word(12'(i), 32'h1000_0000 + 32'(i * 32'h0101_0011));
    load_word(12'd4094, 32'hCAFE_0FFE);
    load_word(12'd4095, 32'hCAFE_0FFF);

    $display("[TB] single beat, timing");
    issue(32'h2000_0000, 8'd0);
    drain(10);
    tick();

    $display("[TB] burst of four");
    issue(32'h2000_0010, 8'd3);
    drain(20);
    tick();

    $display("[TB] below base, then sticky error");
    issue(32'h1FFF_FFFC, 8'd1);
    drain(20);
    repeat (3) tick();
    check_eq("err_sticky", 32'(err_o), 32'd1);

    $display("[TB] burst running past end and address wrap");
    issue(32'h2000_3FF8, 8'd2);
    drain(20);
    issue(32'hFFFF_FFFC, 8'd1);
    drain(20);

    $display("[TB] reset during wait");
    issue(32'h2000_0000, 8'd7);
    reset     = 1'b1;
    r_valid_i = 1'b0;
    sb.delete();
    err_model = 1'b0;
    tick();
    reset = 1'b0;
    repeat (14) tick();
    check_eq("err_cleared", 32'(err_o), 32'd0);
    issue(32'h2000_0020, 8'd1);
    drain(20);

    $display("[TB] back-to-back fetches");
    issue(32'h2000_0030, 8'd0);
    drain(10);
    tick();
    issue(32'h2000_0034, 8'd0);
    drain(10);
    issue(32'h2000_0038, 8'd0);
    drain(10);

    $display("[TB] preload while busy and while idle");
    issue(32'h2000_0000, 8'd3);
    repeat (3) tick();
    check_eq("load_ready_busy", 32'(load_ready_o), 32'd0);
    load_we_i   = 1'b1;
    load_idx_i  = 12'd8;
    load_data_i = 32'hBAD0_BAD0;
    tick();
    load_we_i = 1'b0;
    drain(20);
    issue(32'h2000_0020, 8'd0);
    drain(10);
    load_word(12'd0, 32'h1234_5678);
    issue(32'h2000_0000, 8'd0);
    drain(10);

    $display("[TB] preload in the accept cycle");
    load_we_i   = 1'b1;
    load_idx_i  = 12'd9;
    load_data_i = 32'h5A5A_0009;
    model[9]    = 32'h5A5A_0009;
    issue(32'h2000_0024, 8'd0);
    load_we_i = 1'b0;
    drain(10);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
